// File: rtl/pwm_meter.sv
// pwm_meter: measures an external PWM waveform and reports its duty cycle
// (0..100 %) and frequency (Hz) on the same buses the PWM generator consumes.
// A period is measured between two rising edges, then a single shared
// restoring divider computes frequency first and duty second, and the
// results are published together with a one-cycle update strobe.
module pwm_meter #(
    parameter int unsigned SYSCLK_FRQ  = 50000000,
    parameter int unsigned freq_max    = 10000,
    parameter int unsigned freq_min    = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic        iPWM,
    output logic [6:0]  duty_cycle,
    output logic [13:0] freq_Hz,
    output logic        oValid,
    output logic        oUpdate,
    output logic        oTimeout
);

    // Cycles without a rising edge after which the input counts as stopped
    localparam logic [31:0] TMO        = 32'(SYSCLK_FRQ / freq_min);
    localparam logic [31:0] DIVIDEND_F = 32'(SYSCLK_FRQ);
    localparam logic [31:0] FMAX       = 32'(freq_max);
    localparam logic [31:0] DUTY_MAX   = 32'd100;
    localparam logic [31:0] CNT_SAT    = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ARM,
        MEAS,
        DIVF,
        DIVD,
        UPD
    } state_t;

    // Input synchroniser and edge detection
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pwm_prev_q;
    logic                   s_pwm;
    logic                   rise;
    logic                   fall;

    // Period / high-time counters
    logic [31:0] per_cnt_q, per_cnt_d;
    logic [31:0] hi_cnt_q, hi_cnt_d;

    // Measurement FSM and divider datapath
    state_t      state_q, state_d;
    logic [31:0] period_q, period_d;
    logic [31:0] high_q, high_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] dq_q, dq_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [31:0] qf_q, qf_d;

    // Published results
    logic [6:0]  duty_q, duty_d;
    logic [13:0] freq_q, freq_d;
    logic        valid_q, valid_d;
    logic        update_q, update_d;
    logic        timeout_q, timeout_d;
    logic        measured_q, measured_d;

    // Divider step helpers
    logic [32:0] trial;
    logic        trial_ge;
    logic [31:0] rem_step;
    logic [31:0] dq_step;
    logic [38:0] high_x100;
    logic        timeout_hit;

    assign s_pwm = sync_q[SYNC_STAGES-1];
    assign rise  = s_pwm & ~pwm_prev_q;
    assign fall  = ~s_pwm & pwm_prev_q;

    // Shift the asynchronous PWM input through the synchroniser chain
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            sync_q     <= '0;
            pwm_prev_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], iPWM};
            pwm_prev_q <= s_pwm;
        end
    end

    // Saturating period and high-time counters, restarted on every rising edge
    always_comb begin
        per_cnt_d = per_cnt_q;
        hi_cnt_d  = hi_cnt_q;
        if (rise) begin
            per_cnt_d = 32'd1;
            hi_cnt_d  = 32'd1;
        end else begin
            if (per_cnt_q != CNT_SAT) begin
                per_cnt_d = per_cnt_q + 32'd1;
            end
            if (s_pwm && (hi_cnt_q != CNT_SAT)) begin
                hi_cnt_d = hi_cnt_q + 32'd1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            per_cnt_q <= '0;
            hi_cnt_q  <= '0;
        end else begin
            per_cnt_q <= per_cnt_d;
            hi_cnt_q  <= hi_cnt_d;
        end
    end

    // One restoring-division step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        trial     = {rem_q, dq_q[31]};
        trial_ge  = (trial >= {1'b0, period_q});
        rem_step  = trial_ge ? 32'(trial - {1'b0, period_q}) : trial[31:0];
        dq_step   = {dq_q[30:0], trial_ge};
        high_x100 = 39'(high_q) * 39'd100;
        // Timeouts are only reported once a real measurement has been published
        timeout_hit = (per_cnt_q >= TMO) && measured_q;
    end

    // Measurement FSM: arm, measure, divide twice, publish
    always_comb begin
        state_d    = state_q;
        period_d   = period_q;
        high_d     = high_q;
        rem_d      = rem_q;
        dq_d       = dq_q;
        bit_cnt_d  = bit_cnt_q;
        qf_d       = qf_q;
        duty_d     = duty_q;
        freq_d     = freq_q;
        valid_d    = valid_q;
        update_d   = 1'b0;
        timeout_d  = timeout_q;
        measured_d = measured_q;

        case (state_q)
            ARM: begin
                // While stopped, the duty output tracks the static input level
                if (timeout_q && (rise || fall)) begin
                    duty_d   = s_pwm ? 7'd100 : 7'd0;
                    update_d = 1'b1;
                end
                if (rise) begin
                    state_d = MEAS;
                end else if (timeout_hit && !timeout_q) begin
                    timeout_d = 1'b1;
                    valid_d   = 1'b0;
                    freq_d    = '0;
                    duty_d    = s_pwm ? 7'd100 : 7'd0;
                    update_d  = 1'b1;
                end
            end

            MEAS: begin
                if (rise) begin
                    period_d  = per_cnt_q;
                    high_d    = hi_cnt_q;
                    rem_d     = '0;
                    dq_d      = DIVIDEND_F;
                    bit_cnt_d = '0;
                    state_d   = DIVF;
                end else if (timeout_hit) begin
                    timeout_d = 1'b1;
                    valid_d   = 1'b0;
                    freq_d    = '0;
                    duty_d    = s_pwm ? 7'd100 : 7'd0;
                    update_d  = 1'b1;
                    state_d   = ARM;
                end
            end

            DIVF: begin
                rem_d     = rem_step;
                dq_d      = dq_step;
                bit_cnt_d = bit_cnt_q + 5'd1;
                if (bit_cnt_q == 5'd31) begin
                    // Frequency quotient done; preload the duty division.
                    // The top 7 bits go straight into the remainder because the
                    // duty quotient never exceeds 100.
                    qf_d      = dq_step;
                    rem_d     = {25'd0, high_x100[38:32]};
                    dq_d      = high_x100[31:0];
                    bit_cnt_d = '0;
                    state_d   = DIVD;
                end
            end

            DIVD: begin
                rem_d     = rem_step;
                dq_d      = dq_step;
                bit_cnt_d = bit_cnt_q + 5'd1;
                if (bit_cnt_q == 5'd31) begin
                    state_d = UPD;
                end
            end

            UPD: begin
                duty_d     = (dq_q > DUTY_MAX) ? 7'd100 : dq_q[6:0];
                freq_d     = (qf_q > FMAX) ? FMAX[13:0] : qf_q[13:0];
                valid_d    = 1'b1;
                update_d   = 1'b1;
                timeout_d  = 1'b0;
                measured_d = 1'b1;
                state_d    = MEAS;
            end

            default: begin
                state_d = ARM;
            end
        endcase
    end

    // FSM state and divider registers
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q   <= ARM;
            period_q  <= '0;
            high_q    <= '0;
            rem_q     <= '0;
            dq_q      <= '0;
            bit_cnt_q <= '0;
            qf_q      <= '0;
        end else begin
            state_q   <= state_d;
            period_q  <= period_d;
            high_q    <= high_d;
            rem_q     <= rem_d;
            dq_q      <= dq_d;
            bit_cnt_q <= bit_cnt_d;
            qf_q      <= qf_d;
        end
    end

    // Published output registers
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            duty_q     <= '0;
            freq_q     <= '0;
            valid_q    <= 1'b0;
            update_q   <= 1'b0;
            timeout_q  <= 1'b0;
            measured_q <= 1'b0;
        end else begin
            duty_q     <= duty_d;
            freq_q     <= freq_d;
            valid_q    <= valid_d;
            update_q   <= update_d;
            timeout_q  <= timeout_d;
            measured_q <= measured_d;
        end
    end

    assign duty_cycle = duty_q;
    assign freq_Hz    = freq_q;
    assign oValid     = valid_q;
    assign oUpdate    = update_q;
    assign oTimeout   = timeout_q;

endmodule

// File: tb/tb_pwm_meter.sv
// tb_pwm_meter: directed bench for pwm_meter with a scaled-down system clock
// (1 MHz, freq_min 100 Hz -> timeout after 10000 cycles) so that every case
// including the timeout fits in a short run.
module tb_pwm_meter;

    logic        iCLK   = 1'b0;
    logic        iRST_n = 1'b0;
    logic        iPWM   = 1'b0;
    logic [6:0]  duty_cycle;
    logic [13:0] freq_Hz;
    logic        oValid;
    logic        oUpdate;
    logic        oTimeout;

    int checkCount  = 0;
    int errorCount  = 0;
    int cyc         = 0;
    int updCount    = 0;
    int lastUpdCyc  = 0;
    int lastRiseCyc = 0;
    int updBase     = 0;
    int riseRef     = 0;

    pwm_meter #(
        .SYSCLK_FRQ (1000000),
        .freq_max   (10000),
        .freq_min   (100),
        .SYNC_STAGES(2)
    ) dut (
        .iCLK      (iCLK),
        .iRST_n    (iRST_n),
        .iPWM      (iPWM),
        .duty_cycle(duty_cycle),
        .freq_Hz   (freq_Hz),
        .oValid    (oValid),
        .oUpdate   (oUpdate),
        .oTimeout  (oTimeout)
    );

    // 100 MHz-style clock; absolute time is irrelevant, only cycle counts matter
    always #5 iCLK = ~iCLK;

    // Free-running cycle index
    always @(posedge iCLK) cyc <= cyc + 1;

    // Count cycles with oUpdate high, sampled just after the active edge
    always @(posedge iCLK) begin
        #1;
        if (oUpdate) begin
            updCount   = updCount + 1;
            lastUpdCyc = cyc;
        end
    end

    // Hang guard
    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare one observed value against its expectation
    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checkCount = checkCount + 1;
        if (observed !== expected) begin
            errorCount = errorCount + 1;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one PWM period of P cycles with H high cycles, starting at a negedge
    task automatic applyStimulus(input int p, input int h);
        iPWM        = 1'b1;
        lastRiseCyc = cyc;
        repeat (h) @(negedge iCLK);
        iPWM = 1'b0;
        repeat (p - h) @(negedge iCLK);
    endtask

    initial begin
        iRST_n = 1'b0;
        iPWM   = 1'b0;
        repeat (3) @(negedge iCLK);
        checkOutput("reset duty", duty_cycle, 0);
        checkOutput("reset freq", freq_Hz, 0);
        checkOutput("reset valid", oValid, 0);
        checkOutput("reset update", oUpdate, 0);
        checkOutput("reset timeout", oTimeout, 0);
        iRST_n = 1'b1;
        repeat (5) @(negedge iCLK);

        // 1 kHz, 25 %: nothing after the first rise, result 68 cycles after the second drive
        updBase = updCount;
        applyStimulus(1000, 250);
        checkOutput("no update after first rise", updCount - updBase, 0);
        checkOutput("not valid after first rise", oValid, 0);
        applyStimulus(1000, 250);
        riseRef = lastRiseCyc;
        checkOutput("1k update count", updCount - updBase, 1);
        checkOutput("1k duty", duty_cycle, 25);
        checkOutput("1k freq", freq_Hz, 1000);
        checkOutput("1k valid", oValid, 1);
        checkOutput("1k timeout", oTimeout, 0);
        checkOutput("1k latency", lastUpdCyc - riseRef, 68);

        // 10 kHz, 50 %: every period measured
        updBase = updCount;
        repeat (4) applyStimulus(100, 50);
        checkOutput("10k update count", updCount - updBase, 4);
        checkOutput("10k duty", duty_cycle, 50);
        checkOutput("10k freq", freq_Hz, 10000);

        // 20 kHz, 20 %: frequency saturates at freq_max
        repeat (6) applyStimulus(50, 10);
        checkOutput("20k duty", duty_cycle, 20);
        checkOutput("20k freq saturated", freq_Hz, 10000);

        // 333 Hz with duty just below and just above 1 %
        repeat (2) applyStimulus(3003, 30);
        checkOutput("333Hz duty floor 0", duty_cycle, 0);
        checkOutput("333Hz freq", freq_Hz, 333);
        repeat (2) applyStimulus(3003, 31);
        checkOutput("333Hz duty 1", duty_cycle, 1);
        checkOutput("333Hz freq again", freq_Hz, 333);

        // Hold the input high: timeout after 10000 cycles without a rise
        iPWM = 1'b1;
        repeat (9990) @(negedge iCLK);
        checkOutput("timeout not early", oTimeout, 0);
        checkOutput("valid before timeout", oValid, 1);
        for (int i = 0; i < 300 && !oTimeout; i++) @(negedge iCLK);
        checkOutput("timeout flag", oTimeout, 1);
        checkOutput("timeout valid", oValid, 0);
        checkOutput("timeout freq", freq_Hz, 0);
        checkOutput("timeout duty high", duty_cycle, 100);

        // Static level change while stopped
        updBase = updCount;
        iPWM    = 1'b0;
        repeat (10) @(negedge iCLK);
        checkOutput("stopped low update", updCount - updBase, 1);
        checkOutput("stopped low duty", duty_cycle, 0);
        checkOutput("stopped timeout held", oTimeout, 1);

        // Restart 1 kHz: valid again only after the second rise
        applyStimulus(1000, 250);
        checkOutput("restart not valid yet", oValid, 0);
        applyStimulus(1000, 250);
        checkOutput("restart valid", oValid, 1);
        checkOutput("restart duty", duty_cycle, 25);
        checkOutput("restart freq", freq_Hz, 1000);
        checkOutput("restart timeout cleared", oTimeout, 0);

        // Reset in the middle of the duty division
        iPWM = 1'b1;
        repeat (50) @(negedge iCLK);
        iRST_n = 1'b0;
        iPWM   = 1'b0;
        #1;
        checkOutput("midreset duty", duty_cycle, 0);
        checkOutput("midreset freq", freq_Hz, 0);
        checkOutput("midreset valid", oValid, 0);
        checkOutput("midreset update", oUpdate, 0);
        checkOutput("midreset timeout", oTimeout, 0);
        repeat (3) @(negedge iCLK);
        iRST_n  = 1'b1;
        updBase = updCount;
        applyStimulus(1000, 250);
        checkOutput("post-reset no update", updCount - updBase, 0);
        checkOutput("post-reset not valid", oValid, 0);
        applyStimulus(1000, 250);
        checkOutput("post-reset valid", oValid, 1);
        checkOutput("post-reset duty", duty_cycle, 25);
        checkOutput("post-reset freq", freq_Hz, 1000);

        // Generator loopback pattern: 73 % at 2 kHz, update every period
        updBase = updCount;
        repeat (3) applyStimulus(500, 365);
        checkOutput("2k update count", updCount - updBase, 3);
        checkOutput("2k duty", duty_cycle, 73);
        checkOutput("2k freq", freq_Hz, 2000);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
